// File: rtl/lbm_lattice_reader.sv
// Raster-order readout of the nine per-direction distribution RAMs onto a
// valid/ready stream: one beat per lattice cell, tagged with x, y and last.
module lbm_lattice_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 12,
    parameter int WIDTH         = 64,
    parameter int HEIGHT        = 64,
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [9*DATA_WIDTH-1:0]  rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [9*DATA_WIDTH-1:0]  out_data,
    output logic [XW-1:0]            out_x,
    output logic [YW-1:0]            out_y,
    output logic                     out_last
);

    localparam int BEAT_W = 9 * DATA_WIDTH;
    localparam int DEPTH  = 3;
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [XW-1:0]            x_q, x_d;
    logic [YW-1:0]            y_q, y_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                     inflight_q, inflight_d;
    logic [XW-1:0]            tag_x_q, tag_x_d;
    logic [YW-1:0]            tag_y_q, tag_y_d;
    logic                     tag_last_q, tag_last_d;
    logic [BEAT_W-1:0]        fifo_data_q [DEPTH];
    logic [BEAT_W-1:0]        fifo_data_d [DEPTH];
    logic [XW-1:0]            fifo_x_q [DEPTH];
    logic [XW-1:0]            fifo_x_d [DEPTH];
    logic [YW-1:0]            fifo_y_q [DEPTH];
    logic [YW-1:0]            fifo_y_d [DEPTH];
    logic                     fifo_last_q [DEPTH];
    logic                     fifo_last_d [DEPTH];
    logic [1:0]               wr_ptr_q, wr_ptr_d;
    logic [1:0]               rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q, count_d;

    logic issue;
    logic last_cell;
    logic push;
    logic pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when a FIFO slot is guaranteed for its return,
    // so the FIFO cannot overflow and out_ready never reaches the address path.
    assign last_cell = (x_q == X_MAX) && (y_q == Y_MAX);
    assign issue     = (state_q == ST_RUN) &&
                       (({1'b0, count_q} + {2'b00, inflight_q}) < 3'(DEPTH));
    assign push      = inflight_q;
    assign pop       = (count_q != 2'd0) && out_ready;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        rd_addr_d   = rd_addr_q;
        inflight_d  = 1'b0;
        tag_x_d     = tag_x_q;
        tag_y_d     = tag_y_q;
        tag_last_d  = tag_last_q;
        fifo_data_d = fifo_data_q;
        fifo_x_d    = fifo_x_q;
        fifo_y_d    = fifo_y_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (issue) begin
            rd_addr_d  = addr_q;
            inflight_d = 1'b1;
            tag_x_d    = x_q;
            tag_y_d    = y_q;
            tag_last_d = last_cell;
            addr_d     = addr_q + ADDRESS_WIDTH'(1);
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        // RAM data arrives one cycle after its address; capture it with its tag.
        if (push) begin
            fifo_data_d[wr_ptr_q] = rd_data;
            fifo_x_d[wr_ptr_q]    = tag_x_q;
            fifo_y_d[wr_ptr_q]    = tag_y_q;
            fifo_last_d[wr_ptr_q] = tag_last_q;
            wr_ptr_d              = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            ST_RUN: begin
                if (issue && last_cell) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            tag_x_q    <= '0;
            tag_y_q    <= '0;
            tag_last_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_x_q[i]    <= '0;
                fifo_y_q[i]    <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            rd_addr_q   <= rd_addr_d;
            inflight_q  <= inflight_d;
            tag_x_q     <= tag_x_d;
            tag_y_q     <= tag_y_d;
            tag_last_q  <= tag_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_x_q    <= fifo_x_d;
            fifo_y_q    <= fifo_y_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // The RAM samples the address on the issuing edge; when idle it re-reads the held one.
    assign rd_addr   = issue ? addr_q : rd_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_x     = fifo_x_q[rd_ptr_q];
    assign out_y     = fifo_y_q[rd_ptr_q];
    assign out_last  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_lbm_lattice_reader.sv
// Bench for lbm_lattice_reader: a 4x3 and a 1x1 instance fed from behavioural RAMs,
// every beat checked against the memory contents and raster position it should carry.
module tb_lbm_lattice_reader;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int LW = 9 * DW;
    localparam int WA = 4;
    localparam int HA = 3;
    localparam int NA = WA * HA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_a, busy_a, done_a, out_valid_a, out_ready_a, out_last_a;
    logic [AW-1:0] rd_addr_a;
    logic [LW-1:0] rd_data_a, out_data_a;
    logic [1:0]    out_x_a, out_y_a;

    logic          start_b, busy_b, done_b, out_valid_b, out_ready_b, out_last_b;
    logic [AW-1:0] rd_addr_b;
    logic [LW-1:0] rd_data_b, out_data_b;
    logic [0:0]    out_x_b, out_y_b;

    logic [DW-1:0] ram_a [9][NA];
    logic [DW-1:0] ram_b [9];

    int errors = 0;
    int checks = 0;

    lbm_lattice_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WIDTH(WA), .HEIGHT(HA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_x(out_x_a),
        .out_y(out_y_a), .out_last(out_last_a)
    );

    lbm_lattice_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WIDTH(1), .HEIGHT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_x(out_x_b),
        .out_y(out_y_b), .out_last(out_last_b)
    );

    function automatic logic [LW-1:0] word_a(input int a);
        logic [LW-1:0] w;
        for (int d = 0; d < 9; d++) begin
            w[d*DW +: DW] = (a >= 0 && a < NA) ? ram_a[d][a] : 16'hDEAD;
        end
        return w;
    endfunction

    function automatic logic [LW-1:0] word_b(input int a);
        logic [LW-1:0] w;
        for (int d = 0; d < 9; d++) begin
            w[d*DW +: DW] = (a == 0) ? ram_b[d] : 16'hDEAD;
        end
        return w;
    endfunction

    // Synchronous-read RAMs, one cycle of latency, no enable.
    always @(posedge clk) begin
        rd_data_a <= word_a(int'(rd_addr_a));
        rd_data_b <= word_b(int'(rd_addr_b));
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 held low for the first 20 cycles.
    task automatic run_frame_a(input int ready_mode, input bit hold_start, input int abort_at);
        int            n, cyc, prev_addr, last_acc, first_valid, a;
        bit            fin, aborted, prev_stall;
        logic [LW-1:0] prev_data;
        logic [1:0]    prev_x, prev_y;
        logic          prev_last;
        n = 0; cyc = 0; prev_addr = -1; last_acc = -100; first_valid = -1;
        fin = 1'b0; aborted = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_x = '0; prev_y = '0; prev_last = 1'b0;
        start_a = 1'b1;
        out_ready_a = 1'b0;
        tick();
        while (!fin && cyc < 600) begin
            if (!hold_start) start_a = 1'b0;
            if (cyc == 0) chk("busy_after_start", LW'(busy_a), LW'(1));
            if (busy_a) begin
                a = int'(rd_addr_a);
                chk("rd_addr_no_skip", LW'(a == prev_addr || a == prev_addr + 1), LW'(1));
                chk("outstanding_le_3", LW'((a + 1 - n) <= 3), LW'(1));
                prev_addr = a;
            end
            if (prev_stall) begin
                chk("stall_valid", LW'(out_valid_a), LW'(1));
                chk("stall_data", out_data_a, prev_data);
                chk("stall_x", LW'(out_x_a), LW'(prev_x));
                chk("stall_y", LW'(out_y_a), LW'(prev_y));
                chk("stall_last", LW'(out_last_a), LW'(prev_last));
            end
            if (done_a) begin
                chk("done_timing", LW'(cyc), LW'(last_acc + 2));
                chk("done_beat_count", LW'(n), LW'(NA));
                chk("done_busy", LW'(busy_a), LW'(0));
                chk("done_valid", LW'(out_valid_a), LW'(0));
                fin = 1'b1;
            end else begin
                if (out_valid_a) begin
                    if (first_valid < 0) begin
                        first_valid = cyc;
                        chk("first_valid_latency", LW'(cyc), LW'(2));
                    end
                    chk("beat_in_frame", LW'(n < NA), LW'(1));
                    chk("beat_data", out_data_a, word_a(n));
                    chk("beat_x", LW'(out_x_a), LW'(n % WA));
                    chk("beat_y", LW'(out_y_a), LW'(n / WA));
                    chk("beat_last", LW'(out_last_a), LW'(n == NA - 1));
                end
                if (abort_at >= 0 && out_valid_a && n == abort_at) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    chk("abort_valid", LW'(out_valid_a), LW'(0));
                    chk("abort_busy", LW'(busy_a), LW'(0));
                    chk("abort_last", LW'(out_last_a), LW'(0));
                    start_a = 1'b0;
                    tick();
                    chk("abort_no_done", LW'(done_a), LW'(0));
                    rst = 1'b0;
                    tick();
                    chk("abort_idle_busy", LW'(busy_a), LW'(0));
                    chk("abort_idle_done", LW'(done_a), LW'(0));
                    fin = 1'b1;
                    aborted = 1'b1;
                end else begin
                    case (ready_mode)
                        0:       out_ready_a = 1'b1;
                        1:       out_ready_a = 1'($urandom_range(0, 1));
                        default: out_ready_a = (cyc >= 20);
                    endcase
                    if (ready_mode == 2 && cyc == 19) begin
                        chk("stall_reads_held", LW'(rd_addr_a), LW'(2));
                        chk("stall_no_beats", LW'(n), LW'(0));
                    end
                    prev_stall = out_valid_a && !out_ready_a;
                    prev_data = out_data_a; prev_x = out_x_a;
                    prev_y = out_y_a; prev_last = out_last_a;
                    if (out_valid_a && out_ready_a) begin
                        n++;
                        last_acc = cyc;
                    end
                    tick();
                    cyc++;
                end
            end
        end
        if (!fin) chk("frame_timeout", LW'(0), LW'(1));
        if (!aborted) begin
            out_ready_a = 1'b1;
            tick();
            chk("after_done_busy", LW'(busy_a), LW'(0));
            chk("after_done_single_pulse", LW'(done_a), LW'(0));
            chk("after_done_valid", LW'(out_valid_a), LW'(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; out_ready_a = 1'b0;
        start_b = 1'b0; out_ready_b = 1'b0;
        #2;
        chk("rst_busy", LW'(busy_a), LW'(0));
        chk("rst_done", LW'(done_a), LW'(0));
        chk("rst_valid", LW'(out_valid_a), LW'(0));
        chk("rst_last", LW'(out_last_a), LW'(0));
        chk("rst_rd_addr", LW'(rd_addr_a), LW'(0));
        chk("rst_data", out_data_a, '0);
        chk("rst_x", LW'(out_x_a), LW'(0));
        chk("rst_y", LW'(out_y_a), LW'(0));
        chk("rst_b_valid", LW'(out_valid_b), LW'(0));
        chk("rst_b_busy", LW'(busy_b), LW'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", LW'(busy_a), LW'(0));

        // Patterned RAM: lane d of cell a holds (d<<8)|a.
        for (int d = 0; d < 9; d++)
            for (int i = 0; i < NA; i++)
                ram_a[d][i] = DW'((d << 8) | i);
        run_frame_a(0, 1'b0, -1);
        run_frame_a(1, 1'b0, -1);

        for (int d = 0; d < 9; d++)
            for (int i = 0; i < NA; i++)
                ram_a[d][i] = DW'($urandom);
        run_frame_a(2, 1'b0, -1);
        run_frame_a(0, 1'b0, 5);
        run_frame_a(1, 1'b0, -1);
        run_frame_a(1, 1'b1, -1);
        run_frame_a(0, 1'b0, -1);

        for (int d = 0; d < 9; d++) ram_b[d] = DW'($urandom);
        start_b = 1'b1; out_ready_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_busy", LW'(busy_b), LW'(1));
        chk("b_rd_addr", LW'(rd_addr_b), LW'(0));
        chk("b_c0_valid", LW'(out_valid_b), LW'(0));
        tick();
        chk("b_c1_valid", LW'(out_valid_b), LW'(0));
        tick();
        chk("b_c2_valid", LW'(out_valid_b), LW'(1));
        chk("b_data", out_data_b, word_b(0));
        chk("b_x", LW'(out_x_b), LW'(0));
        chk("b_y", LW'(out_y_b), LW'(0));
        chk("b_last", LW'(out_last_b), LW'(1));
        tick();
        chk("b_c3_valid", LW'(out_valid_b), LW'(0));
        chk("b_c3_done", LW'(done_b), LW'(0));
        tick();
        chk("b_c4_done", LW'(done_b), LW'(1));
        chk("b_c4_busy", LW'(busy_b), LW'(0));
        tick();
        chk("b_c5_done", LW'(done_b), LW'(0));

        // Second 1x1 frame with the beat stalled for three cycles.
        start_b = 1'b1; out_ready_b = 1'b0;
        tick();
        start_b = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("b_stall_valid", LW'(out_valid_b), LW'(1));
            chk("b_stall_data", out_data_b, word_b(0));
            chk("b_stall_last", LW'(out_last_b), LW'(1));
            chk("b_stall_no_done", LW'(done_b), LW'(0));
        end
        out_ready_b = 1'b1;
        tick();
        chk("b_release_valid", LW'(out_valid_b), LW'(0));
        tick();
        chk("b_release_done", LW'(done_b), LW'(1));
        tick();
        chk("b_release_idle", LW'(busy_b | done_b), LW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
